// File: rtl/fitness_eval.sv
// Closed-tour Manhattan fitness evaluator: walks a 30-gene chromosome one gene per cycle.
// Optional duplicate-city penalty enabled by defining FITNESS_DUP_PENALTY_EN.
module fitness_eval #(
    parameter int                COORD_W     = 8,
    parameter int                DIST_W      = 16,
    parameter logic [DIST_W-1:0] DUP_PENALTY = 16'h0400
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               coord_we,
    input  logic [4:0]         coord_addr,
    input  logic [COORD_W-1:0] coord_x,
    input  logic [COORD_W-1:0] coord_y,
    input  logic               start,
    input  logic [149:0]       chromosome,
    output logic               busy,
    output logic               valid,
    output logic [DIST_W-1:0]  fitness,
    output logic [4:0]         dup_count
);

    localparam logic [4:0] LAST_IDX = 5'd29;

    typedef enum logic [2:0] {IDLE, LOAD, WALK, CLOSE, DONE} state_t;

    state_t             state, state_nxt;
    logic [COORD_W-1:0] tab_x [32];
    logic [COORD_W-1:0] tab_y [32];
    logic [149:0]       chrom_q;
    logic [4:0]         idx;
    logic [7:0]         gene_pos;
    logic [4:0]         gene;
    logic [COORD_W-1:0] cur_x, cur_y, prev_x, prev_y, first_x, first_y;
    logic [DIST_W-1:0]  acc;
    logic [DIST_W-1:0]  dist_final;
    logic [DIST_W-1:0]  fit_final;
    logic [4:0]         dup_final;

    function automatic logic [COORD_W-1:0] abs_diff(input logic [COORD_W-1:0] a,
                                                    input logic [COORD_W-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    function automatic logic [DIST_W-1:0] leg_dist(input logic [COORD_W-1:0] xa,
                                                   input logic [COORD_W-1:0] ya,
                                                   input logic [COORD_W-1:0] xb,
                                                   input logic [COORD_W-1:0] yb);
        logic [COORD_W:0] s;
        s = {1'b0, abs_diff(xa, xb)} + {1'b0, abs_diff(ya, yb)};
        return DIST_W'(s);
    endfunction

    function automatic logic [DIST_W-1:0] sat_add(input logic [DIST_W-1:0] a,
                                                  input logic [DIST_W-1:0] b);
        logic [DIST_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[DIST_W] ? {DIST_W{1'b1}} : s[DIST_W-1:0];
    endfunction

    // Control: state register and next-state decode
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = LOAD;
            LOAD:    state_nxt = WALK;
            WALK:    if (idx == LAST_IDX) state_nxt = CLOSE;
            CLOSE:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy  = (state == LOAD) || (state == WALK) || (state == CLOSE);
    assign valid = (state == DONE);

    // Coordinate table: writes are frozen while an evaluation is running
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                tab_x[i] <= '0;
                tab_y[i] <= '0;
            end
        end else if (coord_we && !busy) begin
            tab_x[coord_addr] <= coord_x;
            tab_y[coord_addr] <= coord_y;
        end
    end

    assign gene_pos = 8'(idx) * 8'd5;
    assign gene     = chrom_q[gene_pos +: 5];
    assign cur_x    = tab_x[gene];
    assign cur_y    = tab_y[gene];

    // Walk datapath
    always_ff @(posedge clk) begin
        case (state)
            IDLE: begin
                if (start) begin
                    chrom_q <= chromosome;
                    idx     <= '0;
                end
            end
            LOAD: begin
                prev_x  <= cur_x;
                prev_y  <= cur_y;
                first_x <= cur_x;
                first_y <= cur_y;
                acc     <= '0;
                idx     <= 5'd1;
            end
            WALK: begin
                acc    <= sat_add(acc, leg_dist(cur_x, cur_y, prev_x, prev_y));
                prev_x <= cur_x;
                prev_y <= cur_y;
                idx    <= idx + 5'd1;
            end
            default: ;
        endcase
    end

    assign dist_final = sat_add(acc, leg_dist(prev_x, prev_y, first_x, first_y));

`ifdef FITNESS_DUP_PENALTY_EN
    localparam int PW = DIST_W + 6;

    logic [31:0] seen;
    logic [4:0]  dup;

    function automatic logic [DIST_W-1:0] sat_penalty(input logic [DIST_W-1:0] dist,
                                                      input logic [4:0]        cnt);
        logic [PW-1:0] t;
        t = PW'(dist) + PW'(cnt) * PW'(DUP_PENALTY);
        return (|t[PW-1:DIST_W]) ? {DIST_W{1'b1}} : t[DIST_W-1:0];
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            seen <= '0;
            dup  <= '0;
        end else if (state == LOAD) begin
            seen <= 32'd1 << gene;
            dup  <= '0;
        end else if (state == WALK) begin
            seen <= seen | (32'd1 << gene);
            if (seen[gene] && (dup != 5'd31)) dup <= dup + 5'd1;
        end
    end

    assign fit_final = sat_penalty(dist_final, dup);
    assign dup_final = dup;
`else
    logic unused_penalty;
    assign unused_penalty = ^DUP_PENALTY;
    assign fit_final      = dist_final;
    assign dup_final      = '0;
`endif

    // Result registers: new values coincide with the valid cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            fitness   <= '0;
            dup_count <= '0;
        end else if (state == CLOSE) begin
            fitness   <= fit_final;
            dup_count <= dup_final;
        end
    end

endmodule

// File: tb/tb_fitness_eval.sv
// Directed bench for fitness_eval; expected values follow FITNESS_DUP_PENALTY_EN if defined.
module tb_fitness_eval;

    logic         clk = 1'b0;
    logic         rst;
    logic         coord_we;
    logic [4:0]   coord_addr;
    logic [7:0]   coord_x, coord_y;
    logic         start;
    logic [149:0] chromosome;
    logic         busy, valid, s_busy, s_valid;
    logic [15:0]  fitness, s_fitness;
    logic [4:0]   dup_count, s_dup_count;

    int total = 0;
    int bad   = 0;

`ifdef FITNESS_DUP_PENALTY_EN
    localparam logic [15:0] EXP_CONST_FIT = 16'h7400;
    localparam logic [4:0]  EXP_CONST_DUP = 5'd29;
    localparam logic [15:0] EXP_ALT_FIT   = 16'hABC4;
    localparam logic [4:0]  EXP_ALT_DUP   = 5'd28;
    localparam logic [15:0] EXP_SAT_FIT   = 16'hFFFF;
    localparam logic [4:0]  EXP_SAT_DUP   = 5'd29;
`else
    localparam logic [15:0] EXP_CONST_FIT = 16'h0000;
    localparam logic [4:0]  EXP_CONST_DUP = 5'd0;
    localparam logic [15:0] EXP_ALT_FIT   = 16'h3BC4;
    localparam logic [4:0]  EXP_ALT_DUP   = 5'd0;
    localparam logic [15:0] EXP_SAT_FIT   = 16'h0000;
    localparam logic [4:0]  EXP_SAT_DUP   = 5'd0;
`endif

    fitness_eval dut (
        .clk(clk), .rst(rst), .coord_we(coord_we), .coord_addr(coord_addr),
        .coord_x(coord_x), .coord_y(coord_y), .start(start), .chromosome(chromosome),
        .busy(busy), .valid(valid), .fitness(fitness), .dup_count(dup_count)
    );

    fitness_eval #(.DUP_PENALTY(16'h1000)) dut_sat (
        .clk(clk), .rst(rst), .coord_we(coord_we), .coord_addr(coord_addr),
        .coord_x(coord_x), .coord_y(coord_y), .start(start), .chromosome(chromosome),
        .busy(s_busy), .valid(s_valid), .fitness(s_fitness), .dup_count(s_dup_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_city(input int a, input int x, input int y);
        coord_we   = 1'b1;
        coord_addr = 5'(a);
        coord_x    = 8'(x);
        coord_y    = 8'(y);
        tick();
        coord_we   = 1'b0;
    endtask

    task automatic load_ascending();
        for (int i = 0; i < 32; i++) write_city(i, i, 0);
    endtask

    // mode 0: genes 0..29, mode 1: all 5, otherwise alternating 0,1
    function automatic logic [149:0] chrom_of(input int mode);
        logic [149:0] c;
        c = '0;
        for (int i = 0; i < 30; i++) begin
            case (mode)
                0:       c[5*i +: 5] = 5'(i);
                1:       c[5*i +: 5] = 5'd5;
                default: c[5*i +: 5] = 5'(i % 2);
            endcase
        end
        return c;
    endfunction

    // Starts one evaluation and watches 40 edges; inj_at>0 injects start+write before that edge
    task automatic launch(input logic [149:0] c, input int inj_at,
                          output int lat, output int nvalid, output int nbusy,
                          output logic busy_done);
        chromosome = c;
        start      = 1'b1;
        tick();
        start     = 1'b0;
        lat       = -1;
        nvalid    = 0;
        nbusy     = busy ? 1 : 0;
        busy_done = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            if (i == inj_at) begin
                start      = 1'b1;
                coord_we   = 1'b1;
                coord_addr = 5'd1;
                coord_x    = 8'd0;
                coord_y    = 8'd0;
            end
            tick();
            start    = 1'b0;
            coord_we = 1'b0;
            if (busy) nbusy++;
            if (valid) begin
                nvalid++;
                if (lat < 0) lat = i;
            end
            if (i == 31) busy_done = busy;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; coord_we = 1'b0; coord_addr = '0; coord_x = '0; coord_y = '0;
        start = 1'b0; chromosome = '0;
        tick(); tick();
        rst = 1'b0;
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", valid); end
        total++; if (fitness !== 16'h0) begin bad++; $display("FAIL reset_fitness got=%0h want=0", fitness); end
        total++; if (dup_count !== 5'd0) begin bad++; $display("FAIL reset_dup got=%0d want=0", dup_count); end
    endtask

    task automatic test_ascending();
        int lat, nv, nb;
        logic bd;
        load_ascending();
        launch(chrom_of(0), 0, lat, nv, nb, bd);
        total++; if (lat != 31) begin bad++; $display("FAIL asc_latency got=%0d want=31", lat); end
        total++; if (nv != 1) begin bad++; $display("FAIL asc_valid_count got=%0d want=1", nv); end
        total++; if (nb != 31) begin bad++; $display("FAIL asc_busy_cycles got=%0d want=31", nb); end
        total++; if (bd !== 1'b0) begin bad++; $display("FAIL asc_busy_in_done got=%b want=0", bd); end
        total++; if (fitness !== 16'd58) begin bad++; $display("FAIL asc_fitness got=%0d want=58", fitness); end
        total++; if (dup_count !== 5'd0) begin bad++; $display("FAIL asc_dup got=%0d want=0", dup_count); end
    endtask

    task automatic test_constant();
        int lat, nv, nb;
        logic bd;
        write_city(5, 100, 50);
        launch(chrom_of(1), 0, lat, nv, nb, bd);
        total++; if (nv != 1) begin bad++; $display("FAIL const_valid_count got=%0d want=1", nv); end
        total++; if (fitness !== EXP_CONST_FIT) begin bad++; $display("FAIL const_fitness got=%0h want=%0h", fitness, EXP_CONST_FIT); end
        total++; if (dup_count !== EXP_CONST_DUP) begin bad++; $display("FAIL const_dup got=%0d want=%0d", dup_count, EXP_CONST_DUP); end
        total++; if (s_fitness !== EXP_SAT_FIT) begin bad++; $display("FAIL sat_fitness got=%0h want=%0h", s_fitness, EXP_SAT_FIT); end
        total++; if (s_dup_count !== EXP_SAT_DUP) begin bad++; $display("FAIL sat_dup got=%0d want=%0d", s_dup_count, EXP_SAT_DUP); end
    endtask

    task automatic test_alternating();
        int lat, nv, nb;
        logic bd;
        write_city(0, 0, 0);
        write_city(1, 255, 255);
        launch(chrom_of(2), 0, lat, nv, nb, bd);
        total++; if (lat != 31) begin bad++; $display("FAIL alt_latency got=%0d want=31", lat); end
        total++; if (fitness !== EXP_ALT_FIT) begin bad++; $display("FAIL alt_fitness got=%0h want=%0h", fitness, EXP_ALT_FIT); end
        total++; if (dup_count !== EXP_ALT_DUP) begin bad++; $display("FAIL alt_dup got=%0d want=%0d", dup_count, EXP_ALT_DUP); end
    endtask

    task automatic test_busy_interference();
        int lat, nv, nb;
        logic bd;
        launch(chrom_of(2), 10, lat, nv, nb, bd);
        total++; if (nv != 1) begin bad++; $display("FAIL busy_valid_count got=%0d want=1", nv); end
        total++; if (fitness !== EXP_ALT_FIT) begin bad++; $display("FAIL busy_fitness got=%0h want=%0h", fitness, EXP_ALT_FIT); end
        launch(chrom_of(2), 0, lat, nv, nb, bd);
        total++; if (fitness !== EXP_ALT_FIT) begin bad++; $display("FAIL busy_readback got=%0h want=%0h", fitness, EXP_ALT_FIT); end
    endtask

    task automatic test_reset_abort();
        int lat, nv, nb;
        logic bd;
        chromosome = chrom_of(2);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i <= 10; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", busy); end
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL abort_valid got=%b want=0", valid); end
        total++; if (fitness !== 16'h0) begin bad++; $display("FAIL abort_fitness got=%0h want=0", fitness); end
        total++; if (dup_count !== 5'd0) begin bad++; $display("FAIL abort_dup got=%0d want=0", dup_count); end
        nv = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (valid) nv++;
        end
        total++; if (nv != 0) begin bad++; $display("FAIL abort_no_valid got=%0d want=0", nv); end
        launch(chrom_of(0), 0, lat, nv, nb, bd);
        total++; if (fitness !== 16'd0) begin bad++; $display("FAIL abort_table_cleared got=%0d want=0", fitness); end
        load_ascending();
        launch(chrom_of(0), 0, lat, nv, nb, bd);
        total++; if (lat != 31) begin bad++; $display("FAIL abort_rerun_latency got=%0d want=31", lat); end
        total++; if (fitness !== 16'd58) begin bad++; $display("FAIL abort_rerun_fitness got=%0d want=58", fitness); end
    endtask

    initial begin
        test_reset();
        test_ascending();
        test_constant();
        test_alternating();
        test_busy_interference();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
